alu_seq_32: RTL
===============

ALU_SEQ_32 -- requirements
Module: alu_seq_32

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 op  input  4  operation code.
REQ-007 a  input  32  operand A.
REQ-008 b  input  32  operand B; b[4:0] is the shift amount for shifts.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  32  registered result.
REQ-012 zero  output  1  registered; 1 when result == 0.
REQ-013 overflow  output  1  registered signed overflow flag.
REQ-014 busy  output  1  1 in any state other than IDLE.

Function
REQ-015 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1100 NOR; all other codes yield result 0, overflow 0.
REQ-016 FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE).
REQ-017 Accept occurs on a cycle with in_valid && in_ready; a, b, op captured at that edge; inputs ignored in other states.
REQ-018 Non-shift op accepted: IDLE -> DONE; result/flags written at the accept edge, out_valid high the following cycle (latency 1).
REQ-019 Shift op with b[4:0] == 0: treated as non-shift, result = a, latency 1.
REQ-020 Shift op with b[4:0] = N > 0: IDLE -> SHIFT; working register shifts by 1 bit per cycle; after N shift cycles go to DONE; out_valid first high N+1 cycles after accept.
REQ-021 SRL is logical (zero fill); SLL fills zeros; only b[4:0] used, b[31:5] ignored.
REQ-022 ADD/SUB wrap modulo 2^32; overflow = signed overflow of that operation; overflow = 0 for all other ops.
REQ-023 SLT result = 32'h1 if signed a < signed b else 0, correct even when a - b overflows.
REQ-024 zero reflects the final result only, updated in the same edge as result.
REQ-025 DONE: result, zero, overflow, out_valid held stable while out_ready == 0.
REQ-026 DONE with out_ready == 1: transfer completes, next state IDLE, out_valid low next cycle; max throughput one command per 2 cycles.
REQ-027 in_valid asserted while not IDLE: no capture, command must be held by producer until in_ready.
REQ-028 out_ready asserted while not DONE: no effect.

Reset
REQ-029 rst high at a clock edge forces state IDLE, out_valid 0, result 0, zero 1, overflow 0, shift counter 0, regardless of state, including mid-shift or mid-handshake.
REQ-030 While rst high, in_ready = 0 and no command is accepted; in_ready rises the cycle after rst deasserts.

Structure
REQ-031 Shared package holds opcode constants (OP_AND ... OP_NOR) and the state enumeration.
REQ-032 One sub-module, alu_comb_32, computes the single-cycle ops (AND/OR/ADD/XOR/SUB/SLT/NOR) and overflow combinationally; FSM, shift iteration and output registers live in alu_seq_32.

Verification
REQ-033 OR: a=0xF0F0_0000, b=0x0F0F_00FF, op=0001 -> out_valid 1 cycle later, result 0xFFFF_00FF, zero 0, overflow 0.
REQ-034 ADD overflow: a=0x7FFF_FFFF, b=0x1, op=0010 -> result 0x8000_0000, overflow 1; SUB a=b=0x1234 -> result 0, zero 1.
REQ-035 SLL: a=0x1, b=0x1F, op=0100 -> busy 31+ cycles, out_valid exactly 32 cycles after accept, result 0x8000_0000; SRL b=0 -> result=a after 1 cycle.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0, second in_valid not captured; out_ready 1 -> IDLE next cycle, then second command accepted.
REQ-037 Reset mid-shift: SRL a=0xFFFF_FFFF, b=20, rst at cycle 5 -> next cycle state IDLE, out_valid 0, result 0, zero 1; no stale result emerges later.
REQ-038 SLT: a=0x8000_0000, b=0x7FFF_FFFF -> result 1; undefined op 1111 -> result 0, zero 1.

Source files
------------

// File: rtl/alu_seq_32_pkg.sv
// Shared definitions for the sequential 32-bit ALU.
// Holds the opcode map, the FSM state encoding and a shift-op decode helper.
package alu_seq_32_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_32_if.sv
// Command/result handshake bundle of the sequential ALU.
// master drives commands and accepts results; slave is the ALU itself.
interface alu_seq_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, busy
  );
endinterface

// File: rtl/alu_comb_32.sv
// Single-cycle ALU operations and signed overflow, purely combinational.
// Shift opcodes and unused codes return zero here; shifts are iterated by the parent.
module alu_comb_32
  import alu_seq_32_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      OP_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      // Direct signed compare stays correct when a - b would overflow.
      OP_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_32.sv
// Sequential 32-bit ALU: single-cycle ops complete in one cycle, shifts move
// one bit per cycle; results are held in registers until the consumer takes them.
module alu_seq_32
  import alu_seq_32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_seq_32_if.slave  bus
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] work_reg;
  logic [4:0]  cnt_reg;
  logic        shl_reg;
  logic [31:0] result_reg;
  logic        zero_reg;
  logic        ovf_reg;
  logic        out_valid_reg;

  logic        in_ready;
  logic        accept;
  logic        start_shift;
  logic [31:0] shifted;
  logic [31:0] alu_result;
  logic        alu_ovf;
  logic [31:0] single_result;

  alu_comb_32 u_comb (
    .op       (bus.op),
    .a        (bus.a),
    .b        (bus.b),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  // A shift by zero behaves as a pass-through of a with single-cycle latency.
  assign start_shift   = is_shift(bus.op) && (bus.b[4:0] != 5'd0);
  assign single_result = is_shift(bus.op) ? bus.a : alu_result;
  assign shifted       = shl_reg ? {work_reg[30:0], 1'b0} : {1'b0, work_reg[31:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = start_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == 5'd1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == ST_IDLE) && !rst;
    accept   = bus.in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg      <= '0;
      cnt_reg       <= '0;
      shl_reg       <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (start_shift) begin
              work_reg <= bus.a;
              cnt_reg  <= bus.b[4:0];
              shl_reg  <= (bus.op == OP_SLL);
            end else begin
              result_reg    <= single_result;
              zero_reg      <= (single_result == 32'd0);
              ovf_reg       <= alu_ovf;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work_reg <= shifted;
          cnt_reg  <= cnt_reg - 5'd1;
          // The last shift lands straight in the result register.
          if (cnt_reg == 5'd1) begin
            result_reg    <= shifted;
            zero_reg      <= (shifted == 32'd0);
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = ovf_reg;

endmodule
